adc_spi_rx: RTL

Receives the control frame that the MCU clocks into the FPGA over the ADC SPI link (i_ADC_Clock / i_ADC_Data / i_ADC_CS). It synchronises the link into the i_Clock domain and deserialises 16-bit words, MSB first. When a frame completes correctly, it publishes all words together. It sits directly behind the top-level SPI pins and feeds the oscillator/harmonic engine with frequency, harmonic-scaling and comb parameters.

---
 rtl/addatone_pkg.sv | 9 +
 rtl/sync_edge.sv | 19 +
 rtl/adc_spi_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/addatone_pkg.sv
// addatone_pkg: shared frame geometry, word indices and receiver state encoding
package addatone_pkg;
  localparam int DEFAULT_WORD_BITS = 16;
  localparam int DEFAULT_WORDS = 5;
  localparam int FREQ_IDX = 0;
  localparam int HARM_IDX = 1;
  localparam int COMB_IDX = 2;
  typedef enum logic [1:0] {ARMING, IDLE, RX, DONE} rx_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser with a third stage for rise/fall detection
module sync_edge #(
  parameter logic IDLE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= {3{IDLE}};
    else s <= {s[1:0], d};
  assign level = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: SPI frame receiver, publishes a full frame of words only when it arrives intact
module adc_spi_rx
  import addatone_pkg::*;
#(
  parameter int WORD_BITS = DEFAULT_WORD_BITS,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                       i_Clock,
  input  logic                       reset_n,
  input  logic                       i_ADC_Clock,
  input  logic                       i_ADC_Data,
  input  logic                       i_ADC_CS,
  output logic [WORDS*WORD_BITS-1:0] o_Words,
  output logic                       o_Valid,
  output logic                       o_Frame_Error
);
  localparam int CW = $clog2(WORD_BITS);
  localparam int IW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);
  localparam logic [IW-1:0] FULL_IDX = IW'(WORDS);
  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [1:0] mosi_s;
  rx_state_t state;
  logic [CW-1:0] bit_cnt;
  logic [IW-1:0] word_idx;
  logic [WORD_BITS-1:0] word;
  logic [WORDS*WORD_BITS-1:0] staging;
  logic overrun;
  logic [1:0] arm_cnt;
  logic sample;
  logic [WORD_BITS-1:0] next_word;
  sync_edge #(.IDLE(1'b0)) u_sck (
    .clk(i_Clock), .rst_n(reset_n), .d(i_ADC_Clock),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.IDLE(1'b1)) u_cs (
    .clk(i_Clock), .rst_n(reset_n), .d(i_ADC_CS),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  always_ff @(posedge i_Clock or negedge reset_n)
    if (!reset_n) mosi_s <= '0;
    else mosi_s <= {mosi_s[0], i_ADC_Data};
  assign sample = sck_rise & ~cs_level;
  assign next_word = {word[WORD_BITS-2:0], mosi_s[1]};
  // ARMING needs three consecutive high CS samples so the reset value of the
  // CS synchroniser cannot masquerade as an idle link when a frame is in flight
  always_ff @(posedge i_Clock or negedge reset_n)
    if (!reset_n) begin
      state <= ARMING;
      bit_cnt <= '0;
      word_idx <= '0;
      word <= '0;
      staging <= '0;
      overrun <= 1'b0;
      arm_cnt <= '0;
      o_Words <= '0;
      o_Valid <= 1'b0;
      o_Frame_Error <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      o_Frame_Error <= 1'b0;
      case (state)
        ARMING: begin
          arm_cnt <= cs_level ? arm_cnt + 2'd1 : 2'd0;
          if (cs_level && arm_cnt == 2'd2) state <= IDLE;
        end
        IDLE: if (cs_fall) begin
          bit_cnt <= '0;
          word_idx <= '0;
          word <= '0;
          overrun <= 1'b0;
          state <= RX;
        end
        RX: if (cs_rise) state <= DONE;
        else if (sample) begin
          if (word_idx == FULL_IDX) overrun <= 1'b1;
          else begin
            word <= next_word;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              staging[word_idx*WORD_BITS +: WORD_BITS] <= next_word;
              word_idx <= word_idx + IW'(1);
            end else bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          if (word_idx == FULL_IDX && !overrun && bit_cnt == '0) begin
            o_Words <= staging;
            o_Valid <= 1'b1;
          end else o_Frame_Error <= 1'b1;
          state <= IDLE;
        end
        default: state <= ARMING;
      endcase
    end
  logic unused;
  assign unused = sck_level ^ sck_fall;
endmodule
